mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single memory port of the multi-cycle RISC-V core between two requesters: M0 (the core's fetch/load/store path, driven by the controller's AdrSrc/MemWrite sequencing) and M1 (the debug/program loader).
- Round-robin arbitration, one outstanding transfer at a time, variable-latency memory with a ready handshake, and a per-transfer timeout that returns an error instead of hanging the core.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, maximum BUSY cycles without mem_ready before the transfer is aborted (must be >= 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- m0_req  in  1  M0 request, level, held until m0_ack.
- m0_we  in  1  M0 write enable (1 = write).
- m0_addr  in  AW  M0 address.
- m0_wdata  in  DW  M0 write data.
- m0_rdata  out  DW  M0 read data, valid while m0_ack = 1.
- m0_ack  out  1  one-cycle completion pulse to M0.
- m0_err  out  1  M0 timeout flag, valid with m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: same directions, widths and meanings as M0, for M1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion, sampled only in BUSY.
- busy  out  1  high in BUSY and RESP.
- owner  out  1  index of the granted master; holds its last value in IDLE.

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - state = IDLE.
  - All acks, errs, mem_en, mem_we and busy = 0.
  - All rdata and mem_addr/mem_wdata = 0.
  - owner = 0.
  - last_grant = 1, so M0 wins the first tie.
  - Timeout counter = 0.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - If exactly one req is high, grant that master.
  - If both are high, grant the master that is not last_grant.
  - On grant:
    - Latch we/addr/wdata into the mem_* registers.
    - Set owner and last_grant to the granted master.
    - Clear the counter.
    - Go to BUSY.
  - With no req, stay in IDLE.
- BUSY:
  - mem_en = 1 and mem_we = latched we.
  - Address and data are held stable for the whole state; later changes on the master inputs are ignored.
  - mem_ready = 1: capture mem_rdata into owner's rdata (writes capture 0), err = 0, go to RESP.
  - Otherwise, counter increments. Counter == TIMEOUT-1 with no mem_ready: rdata = 0, err = 1, go to RESP.
  - mem_ready on the timeout cycle counts as success.
- RESP:
  - owner's ack = 1 for exactly this cycle; err is valid alongside it.
  - mem_en = 0.
  - All reqs are ignored in this cycle.
  - Go to IDLE.
- Requester rule: the master drops req (or presents a new request) on the cycle after ack. A req high in IDLE is always a new request.
- Latency: req first seen in IDLE at cycle N, zero-wait memory (mem_ready in the first BUSY cycle). Then mem_en is high at N+1, ack at N+2, and the next grant is possible at N+3. Each memory wait cycle adds 1.
- Non-owner outputs:
  - The non-owner's ack/err are always 0.
  - Its rdata holds its previous value.
- mem_ready outside BUSY is ignored.
- Reset asserted mid-transfer aborts it:
  - No ack is issued and mem_en drops asynchronously.
  - After reset release, arbitration restarts with M0 priority on a tie.

Test Plan:
- Single read: M0 reads 0x0000_0010; memory returns 0xDEADBEEF in the first BUSY cycle -> mem_en high 1 cycle, m0_ack at cycle +2 with m0_rdata = 0xDEADBEEF, m0_err = 0, m1_ack stays 0.
- Write with wait states: M1 writes 0x1234_5678 to 0x100; mem_ready after 3 BUSY cycles -> mem_we = 1 and mem_addr/mem_wdata stable for 3 cycles, m1_ack 1 cycle later, owner = 1.
- Contention fairness: m0_req and m1_req held high for 4 back-to-back transfers -> grant order M0, M1, M0, M1; no master served twice in a row while the other is waiting.
- Timeout: M0 read, mem_ready tied 0, TIMEOUT = 16 -> exactly 16 cycles of mem_en, then m0_ack = 1, m0_err = 1, m0_rdata = 0, FSM back in IDLE.
- Input change during BUSY: M0 read at 0x20, m0_addr switched to 0x40 on cycle 2 of BUSY -> mem_addr stays 0x20 until ack.
- Reset mid-transfer: reset driven low during BUSY -> mem_en, busy and acks drop immediately with no ack; after release with both reqs high, M0 is granted first.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the memory-port arbiter.
// master = arbiter view, slave = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [DW-1:0] m0_rdata;
    logic          m0_ack;
    logic          m0_err;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [DW-1:0] m1_rdata;
    logic          m1_ack;
    logic          m1_err;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic          busy;
    logic          owner;

    modport master (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_rdata, m0_ack, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_rdata, m1_ack, m1_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output busy, owner
    );

    modport slave (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_rdata, m0_ack, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_rdata, m1_ack, m1_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port between two masters,
// one transfer at a time, with a per-transfer timeout that completes with an error.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e        state_q, state_d;
    logic          owner_q;
    logic          last_grant_q;
    logic [CW-1:0] cnt_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          err_q;

    logic          grant_valid;
    logic          grant_idx;
    logic          timeout_hit;
    logic          done;
    logic [DW-1:0] resp_data;

    // On a tie the master that did not win last time is served.
    assign grant_valid = bus.m0_req | bus.m1_req;
    assign grant_idx   = (bus.m0_req & bus.m1_req) ? ~last_grant_q : bus.m1_req;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    assign done        = bus.mem_ready | timeout_hit;
    // Writes and timeouts return zero; mem_ready wins on the timeout cycle.
    assign resp_data   = (bus.mem_ready && !we_q) ? bus.mem_rdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_valid) state_d = StBusy;
            StBusy:  if (done) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            if (state_q == StIdle && grant_valid) begin
                owner_q      <= grant_idx;
                last_grant_q <= grant_idx;
                cnt_q        <= '0;
                we_q         <= grant_idx ? bus.m1_we : bus.m0_we;
                addr_q       <= grant_idx ? bus.m1_addr : bus.m0_addr;
                wdata_q      <= grant_idx ? bus.m1_wdata : bus.m0_wdata;
            end
            if (state_q == StBusy) begin
                if (done) begin
                    err_q <= ~bus.mem_ready;
                    if (owner_q) begin
                        rdata1_q <= resp_data;
                    end else begin
                        rdata0_q <= resp_data;
                    end
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    always_comb begin
        bus.mem_en = 1'b0;
        bus.mem_we = 1'b0;
        bus.busy   = 1'b0;
        bus.m0_ack = 1'b0;
        bus.m1_ack = 1'b0;
        bus.m0_err = 1'b0;
        bus.m1_err = 1'b0;
        unique case (state_q)
            StBusy: begin
                bus.mem_en = 1'b1;
                bus.mem_we = we_q;
                bus.busy   = 1'b1;
            end
            StResp: begin
                bus.busy   = 1'b1;
                bus.m0_ack = ~owner_q;
                bus.m1_ack = owner_q;
                bus.m0_err = ~owner_q & err_q;
                bus.m1_err = owner_q & err_q;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.owner     = owner_q;
endmodule
